xbar_ahb_arb: RTL

Burst- and lock-aware round-robin arbiter that shares one AHB subordinate-side path of the AHB crossbar between up to N_REQ managers. It sits beside each crossbar node output and decides which requester's buffered address phase is forwarded next. It also tracks the data-phase owner so the response mux routes `hrdata`/`hreadyout`/`hresp` back correctly. Grants change only on AHB transfer boundaries, never mid-burst or inside a locked sequence.

---
 rtl/xbar_ahb_pkg.sv | 48 ++++
 rtl/xbar_ahb_arb_rr.sv | 49 ++++
 rtl/xbar_ahb_arb.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/xbar_ahb_pkg.sv
// -----------------------------------------------------------------------------
// xbar_ahb_pkg
// Shared types and helpers for the AHB crossbar arbiter.
//   htrans_e    : AHB HTRANS encoding (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_e    : AHB HBURST encoding
//   arb_state_e : arbiter tracking state (IDLE/BURST/LOCK)
//   burst_count : beats remaining after the NONSEQ of a fixed-length burst
// -----------------------------------------------------------------------------
package xbar_ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_LOCK  = 2'b10
    } arb_state_e;

    // Number of SEQ beats still expected after the NONSEQ; SINGLE and INCR give 0
    // (INCR is tracked by a separate undefined-length flag).
    function automatic logic [3:0] burst_count(input hburst_e hb);
        logic [3:0] cnt;
        case (hb)
            HB_WRAP4,  HB_INCR4:  cnt = 4'd3;
            HB_WRAP8,  HB_INCR8:  cnt = 4'd7;
            HB_WRAP16, HB_INCR16: cnt = 4'd15;
            default:              cnt = 4'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/xbar_ahb_arb_rr.sv
// -----------------------------------------------------------------------------
// xbar_ahb_arb_rr
// Combinational round-robin picker: first asserted request found scanning
// upward from ptr_i, wrapping modulo N_REQ.
// Ports:
//   req_i     : request vector
//   ptr_i     : index where the scan starts
//   win_o     : one-hot winner (zero when nothing requests)
//   win_idx_o : binary winner index (zero when nothing requests)
//   any_o     : at least one request asserted
// -----------------------------------------------------------------------------
module xbar_ahb_arb_rr #(
    parameter int N_REQ     = 2,
    parameter int IDX_WIDTH = 1
) (
    input  logic [N_REQ-1:0]     req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic [N_REQ-1:0]     win_o,
    output logic [IDX_WIDTH-1:0] win_idx_o,
    output logic                 any_o
);

    localparam logic [IDX_WIDTH:0] NREQ_W = (IDX_WIDTH+1)'(N_REQ);

    logic [IDX_WIDTH:0]   w_sum;
    logic [IDX_WIDTH-1:0] w_cand;

    // Scan candidates in rotating order; the first hit wins.
    always_comb begin
        win_o     = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        w_sum     = '0;
        w_cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum  = {1'b0, ptr_i} + (IDX_WIDTH+1)'(k);
            w_sum  = (w_sum >= NREQ_W) ? (w_sum - NREQ_W) : w_sum;
            w_cand = w_sum[IDX_WIDTH-1:0];
            if (!any_o && req_i[w_cand]) begin
                any_o         = 1'b1;
                win_o[w_cand] = 1'b1;
                win_idx_o     = w_cand;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/xbar_ahb_arb.sv
// -----------------------------------------------------------------------------
// xbar_ahb_arb
// Burst- and lock-aware round-robin arbiter for one subordinate-side path of
// the AHB crossbar. Grants move only on transfer boundaries; the data-phase
// owner is tracked for response routing.
// Optional feature: define XBAR_AHB_ARB_LOCK_EN to honour HMASTLOCK.
// Ports:
//   hclk_i, hrst_i      : clock, synchronous active-high reset
//   req_hsel_i          : per-requester select (N_REQ bits)
//   req_htrans_i        : per-requester HTRANS, requester i at [2i+:2]
//   req_hburst_i        : per-requester HBURST, requester i at [HBURST_WIDTH*i+:HBURST_WIDTH]
//   req_hmastlock_i     : per-requester HMASTLOCK
//   hready_i            : shared-path HREADY
//   gnt_o, gnt_idx_o    : address-phase owner (one-hot / binary)
//   dph_idx_o           : data-phase owner
//   dph_valid_o         : NONSEQ/SEQ data phase in progress
//   hmaster_o           : gnt_idx_o zero-extended
//   locked_o            : grant held by a locked sequence
// -----------------------------------------------------------------------------
module xbar_ahb_arb
    import xbar_ahb_pkg::*;
#(
    parameter int   N_REQ         = 2,
    parameter int   HBURST_WIDTH  = 3,
    parameter int   HMASTER_WIDTH = 3,
    localparam int  IDX_WIDTH     = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                            hclk_i,
    input  logic                            hrst_i,
    input  logic [N_REQ-1:0]                req_hsel_i,
    input  logic [2*N_REQ-1:0]              req_htrans_i,
    input  logic [HBURST_WIDTH*N_REQ-1:0]   req_hburst_i,
    input  logic [N_REQ-1:0]                req_hmastlock_i,
    input  logic                            hready_i,
    output logic [N_REQ-1:0]                gnt_o,
    output logic [IDX_WIDTH-1:0]            gnt_idx_o,
    output logic [IDX_WIDTH-1:0]            dph_idx_o,
    output logic                            dph_valid_o,
    output logic [HMASTER_WIDTH-1:0]        hmaster_o,
    output logic                            locked_o
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_REQ - 1);

    arb_state_e             r_state, w_state_n;
    logic [3:0]             r_cnt, w_cnt_n;
    logic                   r_undef, w_undef_n;
    logic [N_REQ-1:0]       r_gnt, w_gnt_n;
    logic [IDX_WIDTH-1:0]   r_gnt_idx, w_gnt_idx_n;
    logic [IDX_WIDTH-1:0]   r_rr_ptr, w_rr_ptr_n;
    logic [IDX_WIDTH-1:0]   r_dph_idx;
    logic                   r_dph_valid;

    htrans_e                w_trans_a [N_REQ];
    logic [HBURST_WIDTH-1:0] w_burst_a [N_REQ];
    logic [N_REQ-1:0]       w_active;
    htrans_e                w_own_trans;
    hburst_e                w_own_burst;
    logic                   w_own_xfer;
    logic                   w_burst_act;
    logic                   w_lock_n;
    logic [N_REQ-1:0]       w_win;
    logic [IDX_WIDTH-1:0]   w_win_idx;
    logic                   w_any;

    // Unpack per-requester fields; a deselected requester is seen as IDLE.
    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        assign w_trans_a[g] = req_hsel_i[g] ? htrans_e'(req_htrans_i[2*g +: 2]) : HT_IDLE;
        assign w_burst_a[g] = req_hburst_i[HBURST_WIDTH*g +: HBURST_WIDTH];
        assign w_active[g]  = req_hsel_i[g] && req_htrans_i[2*g+1];
    end

    xbar_ahb_arb_rr #(
        .N_REQ     (N_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr (
        .req_i     (w_active),
        .ptr_i     (r_rr_ptr),
        .win_o     (w_win),
        .win_idx_o (w_win_idx),
        .any_o     (w_any)
    );

    // Next-state: burst beat tracking, lock tracking, and grant decision.
    // All of it only takes effect on hready_i=1 cycles.
    always_comb begin
        w_own_trans = w_trans_a[r_gnt_idx];
        w_own_burst = hburst_e'(w_burst_a[r_gnt_idx][2:0]);
        w_own_xfer  = w_own_trans[1];
        w_burst_act = (r_cnt != 4'd0) || r_undef;
        w_cnt_n     = r_cnt;
        w_undef_n   = r_undef;
        w_gnt_n     = r_gnt;
        w_gnt_idx_n = r_gnt_idx;
        w_rr_ptr_n  = r_rr_ptr;
        w_lock_n    = 1'b0;

        case (w_own_trans)
            HT_NONSEQ: begin
                // A NONSEQ inside a burst terminates it rather than starting a new one.
                if (w_burst_act) begin
                    w_cnt_n   = 4'd0;
                    w_undef_n = 1'b0;
                end else begin
                    w_cnt_n   = burst_count(w_own_burst);
                    w_undef_n = (w_own_burst == HB_INCR);
                end
            end
            HT_SEQ: begin
                // Stray SEQ with no burst outstanding behaves as a SINGLE.
                if (!w_burst_act) begin
                    w_cnt_n   = 4'd0;
                    w_undef_n = 1'b0;
                end else if (r_undef) begin
                    w_cnt_n   = r_cnt;
                end else begin
                    w_cnt_n   = r_cnt - 4'd1;
                end
            end
            HT_BUSY: begin
                w_cnt_n   = r_cnt;
            end
            HT_IDLE: begin
                w_cnt_n   = 4'd0;
                w_undef_n = 1'b0;
            end
            default: begin
                w_cnt_n   = 4'd0;
                w_undef_n = 1'b0;
            end
        endcase

`ifdef XBAR_AHB_ARB_LOCK_EN
        // Lock follows HMASTLOCK of each accepted transfer; an IDLE can only drop it.
        if (w_own_xfer) begin
            w_lock_n = req_hmastlock_i[r_gnt_idx];
        end else if (w_own_trans == HT_IDLE) begin
            w_lock_n = (r_state == ST_LOCK) && req_hmastlock_i[r_gnt_idx];
        end else begin
            w_lock_n = (r_state == ST_LOCK);
        end
`else
        w_lock_n = 1'b0;
`endif

        if (w_lock_n) begin
            w_state_n = ST_LOCK;
        end else if ((w_cnt_n != 4'd0) || w_undef_n) begin
            w_state_n = ST_BURST;
        end else begin
            w_state_n = ST_IDLE;
        end

        // Re-arbitrate only when the owner is left at a boundary; the pointer
        // moves only if a different requester wins.
        if ((w_state_n == ST_IDLE) && w_any && (w_win_idx != r_gnt_idx)) begin
            w_gnt_n     = w_win;
            w_gnt_idx_n = w_win_idx;
            w_rr_ptr_n  = (w_win_idx == LAST_IDX) ? '0 : (w_win_idx + IDX_WIDTH'(1));
        end else begin
            w_gnt_n     = r_gnt;
            w_gnt_idx_n = r_gnt_idx;
            w_rr_ptr_n  = r_rr_ptr;
        end
    end

    // State registers; everything freezes while hready_i is low.
    always_ff @(posedge hclk_i) begin
        if (hrst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_undef     <= 1'b0;
            r_gnt       <= N_REQ'(1);
            r_gnt_idx   <= '0;
            r_rr_ptr    <= IDX_WIDTH'(1);
            r_dph_idx   <= '0;
            r_dph_valid <= 1'b0;
        end else if (hready_i) begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_undef     <= w_undef_n;
            r_gnt       <= w_gnt_n;
            r_gnt_idx   <= w_gnt_idx_n;
            r_rr_ptr    <= w_rr_ptr_n;
            r_dph_idx   <= r_gnt_idx;
            r_dph_valid <= w_own_xfer;
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_idx_o   = r_gnt_idx;
    assign dph_idx_o   = r_dph_idx;
    assign dph_valid_o = r_dph_valid;
    assign hmaster_o   = HMASTER_WIDTH'(r_gnt_idx);

`ifdef XBAR_AHB_ARB_LOCK_EN
    assign locked_o    = (r_state == ST_LOCK);
`else
    logic w_unused;
    assign w_unused    = ^{req_hmastlock_i, r_state};
    assign locked_o    = 1'b0;
`endif

endmodule
